timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl.sv | 153 +++++++++++++++
 tb/tb_timer_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// Countdown timer with a clock prescaler, pause/resume, auto-reload and a DONE handshake.
// Every output comes straight from a flop.
module timer_ctrl #(
    parameter int unsigned TIMER_WIDTH = 16,
    parameter int unsigned CLK_FREQ    = 100_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [TIMER_WIDTH-1:0] i_load_value,
    input  logic                   i_auto_reload,
    input  logic                   i_pause,
    input  logic                   i_resume,
    input  logic                   i_abort,
    input  logic                   i_ack,
    output logic [TIMER_WIDTH-1:0] o_remaining,
    output logic [TIMER_WIDTH-1:0] o_elapsed,
    output logic [1:0]             o_state,
    output logic                   o_busy,
    output logic                   o_paused,
    output logic                   o_expired
);

    localparam int unsigned PRESC_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_FREQ - 1);
    localparam logic [TIMER_WIDTH-1:0] CNT_ONE = TIMER_WIDTH'(1);
    localparam logic [TIMER_WIDTH-1:0] CNT_MAX = {TIMER_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [PRESC_W-1:0]     presc_q, presc_d;
    logic [TIMER_WIDTH-1:0] remaining_q, remaining_d;
    logic [TIMER_WIDTH-1:0] elapsed_q, elapsed_d;
    logic [TIMER_WIDTH-1:0] reload_q, reload_d;
    logic                   auto_q, auto_d;
    logic                   expired_q, expired_d;
    logic                   busy_q, busy_d;
    logic                   paused_q, paused_d;
    logic                   tick;

    assign tick = (state_q == StRun) && (presc_q == PRESC_MAX);

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        remaining_d = remaining_q;
        elapsed_d   = elapsed_q;
        reload_d    = reload_q;
        auto_d      = auto_q;
        expired_d   = 1'b0;

        if (i_abort) begin
            state_d     = StIdle;
            presc_d     = '0;
            remaining_d = '0;
            elapsed_d   = '0;
        end else if (i_start) begin
            presc_d   = '0;
            elapsed_d = '0;
            if (i_load_value != '0) begin
                state_d     = StRun;
                remaining_d = i_load_value;
                reload_d    = i_load_value;
                auto_d      = i_auto_reload;
            end else begin
                // Zero-length countdown expires immediately; auto-reload is not latched.
                state_d     = StDone;
                remaining_d = '0;
                expired_d   = 1'b1;
            end
        end else begin
            unique case (state_q)
                StRun: begin
                    if (tick) begin
                        presc_d   = '0;
                        elapsed_d = (elapsed_q == CNT_MAX) ? elapsed_q : elapsed_q + 1'b1;
                        if (remaining_q == CNT_ONE) begin
                            expired_d = 1'b1;
                            if (auto_q) begin
                                remaining_d = reload_q;
                            end else begin
                                remaining_d = '0;
                                state_d     = StDone;
                            end
                        end else begin
                            remaining_d = remaining_q - 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                    // A coincident expiry into DONE takes precedence over the pause.
                    if (i_pause && (state_d == StRun)) begin
                        state_d = StPause;
                    end
                end
                StPause: begin
                    if (i_resume) begin
                        state_d = StRun;
                    end
                end
                StDone: begin
                    if (i_ack) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        busy_d   = (state_d == StRun) || (state_d == StPause);
        paused_d = (state_d == StPause);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            presc_q     <= '0;
            remaining_q <= '0;
            elapsed_q   <= '0;
            reload_q    <= '0;
            auto_q      <= 1'b0;
            expired_q   <= 1'b0;
            busy_q      <= 1'b0;
            paused_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            remaining_q <= remaining_d;
            elapsed_q   <= elapsed_d;
            reload_q    <= reload_d;
            auto_q      <= auto_d;
            expired_q   <= expired_d;
            busy_q      <= busy_d;
            paused_q    <= paused_d;
        end
    end

    assign o_state     = state_q;
    assign o_remaining = remaining_q;
    assign o_elapsed   = elapsed_q;
    assign o_busy      = busy_q;
    assign o_paused    = paused_q;
    assign o_expired   = expired_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios plus random commands, all compared every cycle
// against a tick-level behavioural model of the timer.
module tb_timer_ctrl;

    localparam int TW    = 8;
    localparam int CF    = 4;
    localparam int MAXV  = (1 << TW) - 1;
    localparam int IDLE  = 0;
    localparam int RUN   = 1;
    localparam int PAUSE = 2;
    localparam int DONE  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic [TW-1:0] i_load_value = '0;
    logic          i_auto_reload = 1'b0;
    logic          i_pause = 1'b0;
    logic          i_resume = 1'b0;
    logic          i_abort = 1'b0;
    logic          i_ack = 1'b0;
    logic [TW-1:0] o_remaining;
    logic [TW-1:0] o_elapsed;
    logic [1:0]    o_state;
    logic          o_busy;
    logic          o_paused;
    logic          o_expired;

    int errors = 0;
    int checks = 0;

    // Model state: phase counts RUN cycles since the last tick
    int m_state = IDLE, m_rem = 0, m_el = 0, m_phase = 0, m_reload = 0;
    bit m_auto = 0, m_exp = 0;

    timer_ctrl #(
        .TIMER_WIDTH(TW),
        .CLK_FREQ   (CF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_load_value (i_load_value),
        .i_auto_reload(i_auto_reload),
        .i_pause      (i_pause),
        .i_resume     (i_resume),
        .i_abort      (i_abort),
        .i_ack        (i_ack),
        .o_remaining  (o_remaining),
        .o_elapsed    (o_elapsed),
        .o_state      (o_state),
        .o_busy       (o_busy),
        .o_paused     (o_paused),
        .o_expired    (o_expired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_step();
        m_exp = 0;
        if (rst) begin
            m_state = IDLE; m_rem = 0; m_el = 0; m_phase = 0; m_reload = 0; m_auto = 0;
        end else if (i_abort) begin
            m_state = IDLE; m_rem = 0; m_el = 0; m_phase = 0;
        end else if (i_start) begin
            m_phase = 0;
            m_el    = 0;
            if (int'(i_load_value) == 0) begin
                m_state = DONE; m_rem = 0; m_exp = 1;
            end else begin
                m_state = RUN; m_rem = int'(i_load_value);
                m_reload = m_rem; m_auto = i_auto_reload;
            end
        end else if (m_state == RUN) begin
            m_phase = m_phase + 1;
            if (m_phase == CF) begin
                m_phase = 0;
                m_el    = (m_el + 1 > MAXV) ? MAXV : m_el + 1;
                m_rem   = m_rem - 1;
                if (m_rem == 0) begin
                    m_exp = 1;
                    if (m_auto) m_rem = m_reload;
                    else m_state = DONE;
                end
            end
            if (i_pause && m_state == RUN) m_state = PAUSE;
        end else if (m_state == PAUSE) begin
            if (i_resume) m_state = RUN;
        end else if (m_state == DONE) begin
            if (i_ack) m_state = IDLE;
        end
    endfunction

    // One clock: advance the model with the current inputs, then compare after the edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("state", 32'(o_state), m_state);
        check("remaining", 32'(o_remaining), m_rem);
        check("elapsed", 32'(o_elapsed), m_el);
        check("expired", 32'(o_expired), 32'(m_exp));
        check("busy", 32'(o_busy), 32'(m_state == RUN || m_state == PAUSE));
        check("paused", 32'(o_paused), 32'(m_state == PAUSE));
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic cmd_start(input int v, input logic ar);
        i_start = 1'b1; i_load_value = TW'(v); i_auto_reload = ar;
        cycle();
        i_start = 1'b0; i_auto_reload = 1'b0;
    endtask

    task automatic pulse_abort();
        i_abort = 1'b1; cycle(); i_abort = 1'b0;
    endtask

    task automatic pulse_ack();
        i_ack = 1'b1; cycle(); i_ack = 1'b0;
    endtask

    initial begin
        bit prev_exp;

        // Reset
        run(2);
        check("rst_state", 32'(o_state), IDLE);
        check("rst_rem", 32'(o_remaining), 0);
        rst = 1'b0;
        run(1);

        // Basic countdown 3 -> 0
        cmd_start(3, 1'b0);
        check("basic_rem3", 32'(o_remaining), 3);
        run(4);
        check("basic_rem2", 32'(o_remaining), 2);
        run(4);
        check("basic_rem1", 32'(o_remaining), 1);
        run(3);
        check("basic_noexp", 32'(o_expired), 0);
        run(1);
        check("basic_rem0", 32'(o_remaining), 0);
        check("basic_exp", 32'(o_expired), 1);
        check("basic_done", 32'(o_state), DONE);
        check("basic_el3", 32'(o_elapsed), 3);
        run(1);
        check("basic_exp_once", 32'(o_expired), 0);
        pulse_ack();
        check("basic_ack_idle", 32'(o_state), IDLE);

        // Auto-reload with value 2: expiry every 8 cycles
        cmd_start(2, 1'b1);
        for (int k = 1; k <= 24; k++) begin
            cycle();
            check("ar_exp", 32'(o_expired), 32'(k % 8 == 0));
            check("ar_run", 32'(o_state), RUN);
            if (k % 4 == 0) check("ar_rem", 32'(o_remaining), (k % 8 == 0) ? 2 : 1);
        end
        pulse_abort();
        check("abort_idle", 32'(o_state), IDLE);
        check("abort_rem", 32'(o_remaining), 0);
        check("abort_el", 32'(o_elapsed), 0);

        // Pause/resume: prescaler held, decrement two cycles after resume
        cmd_start(5, 1'b0);
        run(2);
        i_pause = 1'b1; cycle(); i_pause = 1'b0;
        check("pause_state", 32'(o_state), PAUSE);
        for (int k = 0; k < 10; k++) begin
            cycle();
            check("pause_hold", 32'(o_remaining), 5);
        end
        i_resume = 1'b1; cycle(); i_resume = 1'b0;
        check("resume_run", 32'(o_state), RUN);
        check("resume_rem5", 32'(o_remaining), 5);
        cycle();
        check("resume_rem4", 32'(o_remaining), 4);

        // Abort during RUN, start+abort together, restart from PAUSE
        pulse_abort();
        check("abort_run_idle", 32'(o_state), IDLE);
        i_abort = 1'b1; cmd_start(4, 1'b0); i_abort = 1'b0;
        check("start_abort_idle", 32'(o_state), IDLE);
        check("start_abort_rem", 32'(o_remaining), 0);
        cmd_start(3, 1'b0);
        run(4);
        i_pause = 1'b1; cycle(); i_pause = 1'b0;
        cmd_start(7, 1'b0);
        check("restart_run", 32'(o_state), RUN);
        check("restart_rem", 32'(o_remaining), 7);
        check("restart_el", 32'(o_elapsed), 0);

        // Zero load, then tick/pause collision at expiry
        cmd_start(0, 1'b1);
        check("zero_done", 32'(o_state), DONE);
        check("zero_exp", 32'(o_expired), 1);
        cycle();
        check("zero_exp_once", 32'(o_expired), 0);
        pulse_ack();
        cmd_start(1, 1'b0);
        run(3);
        i_pause = 1'b1; cycle(); i_pause = 1'b0;
        check("coll_done", 32'(o_state), DONE);
        check("coll_exp", 32'(o_expired), 1);
        check("coll_notpaused", 32'(o_paused), 0);
        pulse_ack();

        // Reset mid-countdown, and reset together with start
        cmd_start(20, 1'b0);
        run(44);
        check("mid_rem9", 32'(o_remaining), 9);
        rst = 1'b1; cycle(); rst = 1'b0;
        check("mid_rst_state", 32'(o_state), IDLE);
        check("mid_rst_rem", 32'(o_remaining), 0);
        check("mid_rst_exp", 32'(o_expired), 0);
        rst = 1'b1; cmd_start(5, 1'b0); rst = 1'b0;
        check("rst_start_idle", 32'(o_state), IDLE);

        // Reload value 1: elapsed saturates, no back-to-back expiry pulses
        cmd_start(1, 1'b1);
        prev_exp = 1'b0;
        for (int k = 0; k < 1100; k++) begin
            cycle();
            check("exp_b2b", 32'(prev_exp && o_expired), 0);
            prev_exp = o_expired;
        end
        check("el_sat", 32'(o_elapsed), MAXV);
        pulse_abort();

        // Random command traffic
        for (int k = 0; k < 3000; k++) begin
            rst           = ($urandom_range(0, 299) == 0);
            i_abort       = ($urandom_range(0, 59) == 0);
            i_start       = ($urandom_range(0, 19) == 0);
            i_load_value  = TW'($urandom_range(0, 6));
            i_auto_reload = 1'($urandom_range(0, 1));
            i_pause       = ($urandom_range(0, 9) == 0);
            i_resume      = ($urandom_range(0, 5) == 0);
            i_ack         = ($urandom_range(0, 4) == 0);
            cycle();
        end
        rst = 1'b0; i_abort = 1'b0; i_start = 1'b0; i_pause = 1'b0;
        i_resume = 1'b0; i_ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
